// File: rtl/vx_mem_responder_if.sv
// Request/response bus between a memory client and vx_mem_responder.
// The master issues reads/writes and consumes responses; the slave is the memory.
interface vx_mem_responder_if #(
  parameter int DATA_SIZE  = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int TAG_WIDTH  = 8
);
  logic                   req_valid;
  logic                   req_rw;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [DATA_SIZE-1:0]   req_byteen;
  logic [8*DATA_SIZE-1:0] req_data;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   req_ready;

  logic                   rsp_valid;
  logic [8*DATA_SIZE-1:0] rsp_data;
  logic [TAG_WIDTH-1:0]   rsp_tag;
  logic                   rsp_ready;

  modport master (
    output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag,
    output req_ready,
    output rsp_valid, rsp_data, rsp_tag,
    input  rsp_ready
  );
endinterface

// File: rtl/vx_mem_responder.sv
// Line-wide memory model: byte-masked writes, fixed-latency reads through a
// never-stalling shift pipeline into a response FIFO, credit-limited issue.
module vx_mem_responder #(
  parameter int DATA_SIZE      = 64,
  parameter int ADDR_WIDTH     = 6,
  parameter int TAG_WIDTH      = 8,
  parameter int LATENCY        = 4,
  parameter int RSP_QUEUE_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_mem_responder_if.slave    mem_if,
  output logic [43:0]          perf_reads,
  output logic [43:0]          perf_writes,
  output logic [43:0]          perf_rsp_stalls
);

  localparam int DW    = 8 * DATA_SIZE;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = $clog2(RSP_QUEUE_SIZE + 1);
  localparam int PTR_W = $clog2(RSP_QUEUE_SIZE);
  localparam logic [CNT_W-1:0] QSIZE = CNT_W'(RSP_QUEUE_SIZE);

  logic [DW-1:0]        mem [DEPTH];

  logic [CNT_W-1:0]     outstanding;
  logic                 req_fire;
  logic                 rd_fire;
  logic                 wr_fire;
  logic                 rsp_fire;

  logic [LATENCY-1:0]   pipe_valid;
  logic [DW-1:0]        pipe_data [LATENCY];
  logic [TAG_WIDTH-1:0] pipe_tag  [LATENCY];

  logic [DW-1:0]        fifo_data [RSP_QUEUE_SIZE];
  logic [TAG_WIDTH-1:0] fifo_tag  [RSP_QUEUE_SIZE];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_push;

  // Credit comes from a registered count only, so a response firing while
  // full does not reopen the request port until the following cycle.
  assign mem_if.req_ready = !reset && (outstanding < QSIZE);
  assign req_fire         = mem_if.req_valid && mem_if.req_ready;
  assign rd_fire          = req_fire && !mem_if.req_rw;
  assign wr_fire          = req_fire && mem_if.req_rw;

  assign fifo_push        = pipe_valid[LATENCY-1];
  assign mem_if.rsp_valid = (fifo_count != '0);
  assign mem_if.rsp_data  = fifo_data[rd_ptr];
  assign mem_if.rsp_tag   = fifo_tag[rd_ptr];
  assign rsp_fire         = mem_if.rsp_valid && mem_if.rsp_ready;

  // Storage array is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < DATA_SIZE; i++) begin
        if (mem_if.req_byteen[i]) begin
          mem[mem_if.req_addr][8*i +: 8] <= mem_if.req_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= rd_fire;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  // The line is captured at the accept edge, so a write one cycle earlier is visible.
  always_ff @(posedge clk) begin
    if (rd_fire) begin
      pipe_data[0] <= mem[mem_if.req_addr];
      pipe_tag[0]  <= mem_if.req_tag;
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_data[i] <= pipe_data[i-1];
      pipe_tag[i]  <= pipe_tag[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data[wr_ptr] <= pipe_data[LATENCY-1];
      fifo_tag[wr_ptr]  <= pipe_tag[LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rsp_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (fifo_push && !rsp_fire) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (!fifo_push && rsp_fire) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  // Outstanding covers both pipeline and FIFO, which is what bounds FIFO occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else if (rd_fire && !rsp_fire) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (!rd_fire && rsp_fire) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reads      <= '0;
      perf_writes     <= '0;
      perf_rsp_stalls <= '0;
    end else begin
      if (rd_fire) begin
        perf_reads <= perf_reads + 44'd1;
      end
      if (wr_fire) begin
        perf_writes <= perf_writes + 44'd1;
      end
      if (mem_if.rsp_valid && !mem_if.rsp_ready) begin
        perf_rsp_stalls <= perf_rsp_stalls + 44'd1;
      end
    end
  end

endmodule

// File: doc/vx_mem_responder.md
VX_MEM_RESPONDER -- requirements
Module: VX_mem_responder

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64: line size in bytes; data width = 8*DATA_SIZE.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6: line address width; array depth = 2^ADDR_WIDTH lines.
REQ-003 SHALL have parameter TAG_WIDTH, default 8: request/response tag width.
REQ-004 SHALL have parameter LATENCY, default 4: cycles from read accept to earliest rsp_valid; legal range >= 1.
REQ-005 SHALL have parameter RSP_QUEUE_SIZE, default 4: maximum outstanding reads; power of two, >= 2.
REQ-006 clk  input  1  sole clock; all state updates on posedge.
REQ-007 reset  input  1  reset is synchronous and active-high.
REQ-008 req_valid  input  1  request valid.
REQ-009 req_rw  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_WIDTH  line address.
REQ-011 req_byteen  input  DATA_SIZE  write byte enables.
REQ-012 req_data  input  8*DATA_SIZE  write data.
REQ-013 req_tag  input  TAG_WIDTH  request tag.
REQ-014 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-015 rsp_valid  output  1  read response valid.
REQ-016 rsp_data  output  8*DATA_SIZE  read data.
REQ-017 rsp_tag  output  TAG_WIDTH  tag of the originating read.
REQ-018 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-019 perf_reads, perf_writes, perf_rsp_stalls  output  44 each  accepted reads, accepted writes, cycles with rsp_valid && !rsp_ready.

Function
REQ-020 Handshake: valid/ready; the block SHALL NOT make req_ready depend combinationally on req_valid; rsp_valid, rsp_data and rsp_tag SHALL hold stable while rsp_valid && !rsp_ready.
REQ-021 Write accept: bytes with req_byteen[i]=1 SHALL be updated at the accept edge; other bytes unchanged; writes produce no response.
REQ-022 Read accept: line SHALL be sampled at the accept edge; a read accepted the cycle after a write to the same address SHALL return the written data.
REQ-023 Read path: LATENCY-stage valid/data/tag shift pipeline feeding an RSP_QUEUE_SIZE-entry FIFO; the pipeline SHALL never stall.
REQ-024 Latency: with FIFO empty and rsp_ready=1, read accepted at edge T SHALL present rsp_valid during cycle T+LATENCY.
REQ-025 Ordering: responses SHALL be returned in read-accept order; no response is dropped or duplicated.
REQ-026 Credit counter: outstanding (width clog2(RSP_QUEUE_SIZE+1)) +1 on read accept, -1 on response fire; both in the same cycle -> unchanged.
REQ-027 req_ready = (outstanding < RSP_QUEUE_SIZE); writes are also blocked when full. This guarantees FIFO never overflows.
REQ-028 Full boundary: outstanding == RSP_QUEUE_SIZE -> req_ready=0 even if a response fires that cycle (registered credit, no same-cycle bypass).
REQ-029 FIFO empty -> rsp_valid=0; pipeline output and FIFO push in same cycle as pop SHALL be legal.
REQ-030 Perf counters SHALL increment by at most 1 per cycle and wrap modulo 2^44.

Reset
REQ-031 On reset: req_ready=0 during the reset cycle, =1 first cycle after; rsp_valid=0; outstanding=0; pipeline valids and FIFO cleared; perf counters=0.
REQ-032 Reset mid-operation SHALL discard all in-flight reads (no later response); array contents SHALL NOT be altered by reset.

Verification
REQ-033 Write addr 5, byteen all-1, data 0xA5..A5, tag 3; next cycle read addr 5 tag 7 -> rsp_data 0xA5..A5, rsp_tag 7 exactly LATENCY=4 cycles after read accept; no response for the write.
REQ-034 Partial write byteen=0x1 data 0x11 over line 0xA5..A5 -> read returns byte0=0x11, others 0xA5.
REQ-035 rsp_ready=0, issue 5 reads tags 1..5 back-to-back -> 4 accepted, req_ready=0 after 4th; raise rsp_ready -> tags 1,2,3,4 in order, then 5th accepted; perf_rsp_stalls counts stalled cycles.
REQ-036 Full counter with simultaneous rsp fire and new read request -> req_ready stays 0 that cycle, read accepted next cycle, outstanding stays 4.
REQ-037 Reset asserted with 3 reads in flight -> rsp_valid=0 next cycle, no stale responses afterward, previously written data still readable.
REQ-038 Random traffic, random rsp_ready, against reference model -> data/tag match, order preserved, perf_reads/perf_writes equal accepted counts.
